// File: rtl/counter_4_bit_ctrl.sv
// Sequencing controller for the 4-bit counter datapath: start/stop command handling,
// prescaled stepping, one-shot or auto-reload runs, busy/done reporting.
module counter_4_bit_ctrl #(
    parameter int unsigned PRESCALE = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       up,
    input  logic       reload,
    input  logic [3:0] init_val,
    input  logic [3:0] term_val,
    input  logic [3:0] cnt_q,
    output logic       cnt_load,
    output logic [3:0] cnt_din,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          up_q, up_d;
    logic          reload_q, reload_d;
    logic [3:0]    init_q, init_d;
    logic [3:0]    term_q, term_d;
    logic          cnt_load_q, cnt_load_d;
    logic          cnt_en_q, cnt_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    cnt_cur;

    // Strobes are registered, so the datapath lags one edge behind our decisions;
    // compare against the value it will hold once the pending strobe lands.
    always_comb begin
        cnt_cur = cnt_q;
        if (cnt_load_q) begin
            cnt_cur = init_q;
        end else if (cnt_en_q) begin
            cnt_cur = up_q ? cnt_q + 4'd1 : cnt_q - 4'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        up_d       = up_q;
        reload_d   = reload_q;
        init_d     = init_q;
        term_d     = term_q;
        cnt_load_d = 1'b0;
        cnt_en_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    up_d       = up;
                    reload_d   = reload;
                    init_d     = init_val;
                    term_d     = term_val;
                    cnt_load_d = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                presc_d = '0;
                state_d = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (!pause) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (cnt_cur != term_q) begin
                            cnt_en_d = 1'b1;
                        end else if (reload_q) begin
                            cnt_load_d = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            up_q       <= 1'b0;
            reload_q   <= 1'b0;
            init_q     <= '0;
            term_q     <= '0;
            cnt_load_q <= 1'b0;
            cnt_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            up_q       <= up_d;
            reload_q   <= reload_d;
            init_q     <= init_d;
            term_q     <= term_d;
            cnt_load_q <= cnt_load_d;
            cnt_en_q   <= cnt_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cnt_load = cnt_load_q;
    assign cnt_din  = init_q;
    assign cnt_en   = cnt_en_q;
    assign cnt_up   = up_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
